uart_tx_scheduler: RTL and testbench

Round-robin scheduler that shares one `uart_encode` packet transmitter among `NUM_REQ` packet sources on the baud clock. It latches the winning requester's packet and drives the encoder's `sys_packet`/`ready` inputs. It waits for a qualified `done`, acknowledges the requester, and enforces a programmable idle gap between packets. It sits between the system packet producers and the UART encoder in the receiver's telemetry path.

---
 rtl/uart_tx_scheduler.sv | 168 ++++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_scheduler.sv
// Round-robin arbiter sharing one uart_encode transmitter among NUM_REQ packet sources.
// Optional SEND watchdog with sticky timeout_err: define UART_SCHED_TIMEOUT_EN.
module uart_tx_scheduler #(
    parameter int NUM_REQ        = 4,
    parameter int PACKET_WIDTH   = 4,
    parameter int GAP_BAUDS      = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                              clk_baud,
    input  logic                              reset,
    input  logic [NUM_REQ-1:0]                req,
    input  logic [NUM_REQ*PACKET_WIDTH*8-1:0] packets,
    output logic [NUM_REQ-1:0]                grant,
    output logic [NUM_REQ-1:0]                ack,
    output logic [PACKET_WIDTH*8-1:0]         enc_packet,
    output logic                              enc_ready,
    input  logic                              enc_done,
    output logic                              busy
`ifdef UART_SCHED_TIMEOUT_EN
    ,
    output logic                              timeout_err
`endif
);

    localparam int          PW    = PACKET_WIDTH * 8;
    localparam int          PTR_W = $clog2(NUM_REQ);
    localparam int unsigned NREQ  = NUM_REQ;

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic [PW-1:0]      enc_packet_q, enc_packet_d;
    logic               enc_ready_q, enc_ready_d;
    logic               busy_q, busy_d;
    logic               armed_q, armed_d;
    logic [7:0]         gap_cnt_q, gap_cnt_d;

`ifdef UART_SCHED_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            timeout_err_q, timeout_err_d;
`endif

    logic             found;
    logic [PTR_W-1:0] win;

    // Search starts just past the last owner so a persistent requester yields to all others.
    always_comb begin
        int unsigned      idx;
        logic [PTR_W-1:0] cand;
        found = 1'b0;
        win   = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = 32'(ptr_q) + 1 + i;
            if (idx >= NREQ) idx = idx - NREQ;
            cand = PTR_W'(idx);
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    always_comb begin
        logic finish;
        state_d      = state_q;
        ptr_d        = ptr_q;
        grant_d      = grant_q;
        ack_d        = '0;
        enc_packet_d = enc_packet_q;
        enc_ready_d  = enc_ready_q;
        armed_d      = armed_q;
        gap_cnt_d    = gap_cnt_q;
        finish       = 1'b0;
`ifdef UART_SCHED_TIMEOUT_EN
        to_cnt_d      = to_cnt_q;
        timeout_err_d = timeout_err_q;
`endif
        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d      = {{(NUM_REQ-1){1'b0}}, 1'b1} << win;
                    enc_packet_d = packets[int'(win)*PW +: PW];
                    enc_ready_d  = 1'b1;
                    ptr_d        = win;
                    armed_d      = 1'b0;
                    state_d      = SEND;
`ifdef UART_SCHED_TIMEOUT_EN
                    to_cnt_d     = '0;
`endif
                end
            end
            SEND: begin
                // enc_done is still high from the previous packet; only a high after a sampled low counts.
                if (!enc_done) armed_d = 1'b1;
                if (armed_q && enc_done) begin
                    finish = 1'b1;
                end
`ifdef UART_SCHED_TIMEOUT_EN
                else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    finish        = 1'b1;
                    timeout_err_d = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
`endif
                if (finish) begin
                    enc_ready_d = 1'b0;
                    grant_d     = '0;
                    ack_d       = grant_q;
                    gap_cnt_d   = 8'(GAP_BAUDS - 1);
                    state_d     = (GAP_BAUDS == 0) ? IDLE : GAP;
                end
            end
            GAP: begin
                if (gap_cnt_q == 8'd0) state_d = IDLE;
                else                   gap_cnt_d = gap_cnt_q - 8'd1;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_baud) begin
        if (reset) begin
            state_q      <= IDLE;
            ptr_q        <= PTR_W'(NUM_REQ - 1);
            grant_q      <= '0;
            ack_q        <= '0;
            enc_packet_q <= '0;
            enc_ready_q  <= 1'b0;
            busy_q       <= 1'b0;
            armed_q      <= 1'b0;
            gap_cnt_q    <= '0;
`ifdef UART_SCHED_TIMEOUT_EN
            to_cnt_q      <= '0;
            timeout_err_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            grant_q      <= grant_d;
            ack_q        <= ack_d;
            enc_packet_q <= enc_packet_d;
            enc_ready_q  <= enc_ready_d;
            busy_q       <= busy_d;
            armed_q      <= armed_d;
            gap_cnt_q    <= gap_cnt_d;
`ifdef UART_SCHED_TIMEOUT_EN
            to_cnt_q      <= to_cnt_d;
            timeout_err_q <= timeout_err_d;
`endif
        end
    end

    assign grant      = grant_q;
    assign ack        = ack_q;
    assign enc_packet = enc_packet_q;
    assign enc_ready  = enc_ready_q;
    assign busy       = busy_q;
`ifdef UART_SCHED_TIMEOUT_EN
    assign timeout_err = timeout_err_q;
`endif

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler with a behavioural encoder (done low 1 cycle after ready, high 22 later).
module tb_uart_tx_scheduler;

    localparam int NR = 4;
    localparam int PB = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [NR-1:0]     req = '0;
    logic [NR*PB-1:0]  packets = '0;
    logic [NR-1:0]     grant, ack;
    logic [PB-1:0]     enc_packet;
    logic              enc_ready, enc_done, busy;
`ifdef UART_SCHED_TIMEOUT_EN
    logic              timeout_err;
`endif

    uart_tx_scheduler #(
        .NUM_REQ(NR), .PACKET_WIDTH(2), .GAP_BAUDS(2), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk_baud(clk), .reset(reset), .req(req), .packets(packets),
        .grant(grant), .ack(ack), .enc_packet(enc_packet), .enc_ready(enc_ready),
        .enc_done(enc_done), .busy(busy)
`ifdef UART_SCHED_TIMEOUT_EN
        , .timeout_err(timeout_err)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Encoder model: starts on a fresh enc_ready, drops done next edge, raises it 22 edges later.
    logic model_en = 1'b1;
    logic served, running;
    int   mcnt;
    always @(posedge clk) begin
        if (reset) begin
            enc_done <= 1'b1; served <= 1'b0; running <= 1'b0; mcnt <= 0;
        end else begin
            if (!enc_ready) served <= 1'b0;
            if (running) begin
                mcnt <= mcnt + 1;
                if (mcnt == 21) begin enc_done <= 1'b1; running <= 1'b0; end
            end else if (enc_ready && !served && model_en) begin
                served <= 1'b1; running <= 1'b1; mcnt <= 0; enc_done <= 1'b0;
            end
        end
    end

    typedef struct { logic [NR-1:0] g; logic [PB-1:0] p; } exp_t;
    exp_t sb_q[$];
    exp_t e;
    int   mptr;
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic tick;
        @(posedge clk); #1;
    endtask

    task automatic push_exp(input logic [NR-1:0] r);
        exp_t x;
        logic [NR-1:0] t;
        for (int k = 1; k <= NR; k++) begin
            t = r >> ((mptr + k) % NR);
            if (t[0]) begin
                mptr = (mptr + k) % NR;
                x.g = 4'b0001 << mptr;
                x.p = packets[mptr*PB +: PB];
                sb_q.push_back(x);
                return;
            end
        end
    endtask

    task automatic pop_exp;
        if (sb_q.size() > 0) e = sb_q.pop_front();
        else begin e.g = 'x; e.p = 'x; end
    endtask

    task automatic wait_grant(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            tick;
            if (grant !== '0) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_ack(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            tick;
            if (ack !== '0) begin ok = 1'b1; break; end
        end
    endtask

    task automatic do_reset;
        reset = 1'b1; req = '0;
        tick; tick;
        reset = 1'b0; mptr = NR - 1;
        sb_q.delete();
    endtask

    task automatic test_reset;
        packets = {16'hD00D, 16'hA55A, 16'h1234, 16'hBEEF};
        reset = 1'b1; req = '0;
        tick; tick;
        n_cmp++; if (grant !== 4'b0) begin n_bad++; $display("FAIL reset_grant: got %b want 0000", grant); end
        n_cmp++; if (ack !== 4'b0) begin n_bad++; $display("FAIL reset_ack: got %b want 0000", ack); end
        n_cmp++; if (enc_packet !== 16'h0) begin n_bad++; $display("FAIL reset_packet: got %h want 0000", enc_packet); end
        n_cmp++; if (enc_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %b want 0", enc_ready); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
`ifdef UART_SCHED_TIMEOUT_EN
        n_cmp++; if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL reset_terr: got %b want 0", timeout_err); end
`endif
        reset = 1'b0; mptr = NR - 1; sb_q.delete();
    endtask

    task automatic test_single;
        bit ok; int c0;
        req = 4'b0100; push_exp(req); c0 = cyc;
        tick; pop_exp;
        n_cmp++; if (grant !== e.g) begin n_bad++; $display("FAIL single_grant: got %b want %b", grant, e.g); end
        n_cmp++; if (enc_packet !== 16'hA55A || e.p !== 16'hA55A) begin n_bad++; $display("FAIL single_packet: got %h want A55A", enc_packet); end
        n_cmp++; if (enc_ready !== 1'b1 || busy !== 1'b1) begin n_bad++; $display("FAIL single_ready_busy: got %b%b want 11", enc_ready, busy); end
        wait_ack(ok);
        n_cmp++; if (!ok || ack !== 4'b0100) begin n_bad++; $display("FAIL single_ack: got %b want 0100", ack); end
        n_cmp++; if (grant !== 4'b0 || enc_ready !== 1'b0) begin n_bad++; $display("FAIL single_release: got %b/%b want 0000/0", grant, enc_ready); end
        req = '0;
        tick;
        n_cmp++; if (ack !== 4'b0 || busy !== 1'b1) begin n_bad++; $display("FAIL single_ack_pulse: got ack %b busy %b want 0000 1", ack, busy); end
        tick;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL single_busy_end: got %b want 0", busy); end
    endtask

    task automatic test_contention;
        bit ok; int last_ack;
        do_reset;
        req = 4'b1111;
        for (int k = 0; k < 5; k++) push_exp(req);
        last_ack = 0;
        for (int k = 0; k < 5; k++) begin
            wait_grant(ok); pop_exp;
            n_cmp++; if (!ok || grant !== e.g) begin n_bad++; $display("FAIL rr_grant%0d: got %b want %b", k, grant, e.g); end
            n_cmp++; if (enc_packet !== e.p) begin n_bad++; $display("FAIL rr_packet%0d: got %h want %h", k, enc_packet, e.p); end
            if (k > 0) begin
                n_cmp++; if (cyc - last_ack != 3) begin n_bad++; $display("FAIL rr_gap%0d: got %0d want 3", k, cyc - last_ack); end
            end
            wait_ack(ok);
            n_cmp++; if (!ok || ack !== e.g) begin n_bad++; $display("FAIL rr_ack%0d: got %b want %b", k, ack, e.g); end
            last_ack = cyc;
            if (k == 4) req = '0;
        end
        repeat (6) tick;
        n_cmp++; if (grant !== 4'b0) begin n_bad++; $display("FAIL rr_quiet: got %b want 0000", grant); end
    endtask

    task automatic test_stale_done;
        bit ok; int seen, en_c;
        do_reset;
        model_en = 1'b0;
        req = 4'b0001; push_exp(req);
        wait_grant(ok); pop_exp;
        n_cmp++; if (!ok || grant !== e.g) begin n_bad++; $display("FAIL stale_grant: got %b want %b", grant, e.g); end
        seen = 0;
        repeat (30) begin tick; if (ack !== 4'b0) seen++; end
        n_cmp++; if (seen != 0) begin n_bad++; $display("FAIL stale_no_ack: got %0d acks want 0", seen); end
        model_en = 1'b1; en_c = cyc;
        wait_ack(ok);
        n_cmp++; if (!ok || ack !== 4'b0001) begin n_bad++; $display("FAIL stale_ack: got %b want 0001", ack); end
        n_cmp++; if (cyc - en_c != 24) begin n_bad++; $display("FAIL stale_latency: got %0d want 24", cyc - en_c); end
        req = '0;
    endtask

    task automatic test_stability;
        bit ok; int extra;
        do_reset;
        req = 4'b0010; push_exp(req);
        wait_grant(ok); pop_exp;
        n_cmp++; if (!ok || grant !== e.g || enc_packet !== e.p) begin n_bad++; $display("FAIL stab_grant: got %b/%h want %b/%h", grant, enc_packet, e.g, e.p); end
        repeat (5) tick;
        packets = ~packets; req = '0;
        tick;
        n_cmp++; if (enc_packet !== e.p || grant !== e.g) begin n_bad++; $display("FAIL stab_hold: got %b/%h want %b/%h", grant, enc_packet, e.g, e.p); end
        wait_ack(ok);
        n_cmp++; if (!ok || ack !== 4'b0010) begin n_bad++; $display("FAIL stab_ack: got %b want 0010", ack); end
        n_cmp++; if (enc_packet !== e.p) begin n_bad++; $display("FAIL stab_packet_after: got %h want %h", enc_packet, e.p); end
        extra = 0;
        repeat (6) begin tick; if (grant !== 4'b0) extra++; end
        n_cmp++; if (extra != 0) begin n_bad++; $display("FAIL stab_no_regrant: got %0d want 0", extra); end
        packets = {16'hD00D, 16'hA55A, 16'h1234, 16'hBEEF};
    endtask

    task automatic test_reset_mid_send;
        bit ok;
        do_reset;
        req = 4'b0100; push_exp(req);
        wait_grant(ok); pop_exp;
        n_cmp++; if (!ok || grant !== e.g) begin n_bad++; $display("FAIL rst_mid_grant: got %b want %b", grant, e.g); end
        repeat (4) tick;
        reset = 1'b1;
        tick;
        n_cmp++; if (grant !== 4'b0 || ack !== 4'b0) begin n_bad++; $display("FAIL rst_mid_grant_ack: got %b/%b want 0000/0000", grant, ack); end
        n_cmp++; if (enc_packet !== 16'h0 || enc_ready !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL rst_mid_outputs: got %h/%b/%b want 0000/0/0", enc_packet, enc_ready, busy); end
        reset = 1'b0; mptr = NR - 1; sb_q.delete();
        req = 4'b0011; push_exp(req);
        wait_grant(ok); pop_exp;
        n_cmp++; if (!ok || grant !== 4'b0001 || grant !== e.g) begin n_bad++; $display("FAIL rst_mid_regrant: got %b want 0001", grant); end
        n_cmp++; if (enc_packet !== e.p) begin n_bad++; $display("FAIL rst_mid_packet: got %h want %h", enc_packet, e.p); end
        wait_ack(ok);
        n_cmp++; if (!ok || ack !== 4'b0001) begin n_bad++; $display("FAIL rst_mid_ack: got %b want 0001", ack); end
        req = '0;
    endtask

`ifdef UART_SCHED_TIMEOUT_EN
    task automatic test_timeout;
        bit ok; int gc;
        do_reset;
        model_en = 1'b0;
        req = 4'b0001; push_exp(req);
        wait_grant(ok); pop_exp; gc = cyc;
        n_cmp++; if (!ok || grant !== e.g || timeout_err !== 1'b0) begin n_bad++; $display("FAIL to_grant: got %b/%b want %b/0", grant, timeout_err, e.g); end
        wait_ack(ok);
        n_cmp++; if (!ok || ack !== 4'b0001) begin n_bad++; $display("FAIL to_ack: got %b want 0001", ack); end
        n_cmp++; if (cyc - gc != 16) begin n_bad++; $display("FAIL to_latency: got %0d want 16", cyc - gc); end
        n_cmp++; if (timeout_err !== 1'b1) begin n_bad++; $display("FAIL to_flag: got %b want 1", timeout_err); end
        model_en = 1'b1;
        req = 4'b0010; push_exp(req);
        wait_grant(ok); pop_exp;
        n_cmp++; if (!ok || grant !== e.g) begin n_bad++; $display("FAIL to_next_grant: got %b want %b", grant, e.g); end
        wait_ack(ok);
        n_cmp++; if (!ok || ack !== 4'b0010) begin n_bad++; $display("FAIL to_next_ack: got %b want 0010", ack); end
        req = '0;
        tick;
        n_cmp++; if (timeout_err !== 1'b1) begin n_bad++; $display("FAIL to_sticky: got %b want 1", timeout_err); end
    endtask
`endif

    initial begin
        test_reset;
        test_single;
        test_contention;
        test_stale_done;
        test_stability;
        test_reset_mid_send;
`ifdef UART_SCHED_TIMEOUT_EN
        test_timeout;
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
